// File: rtl/csr_exec_pkg.sv
// rtl/csr_exec_pkg.sv - shared encodings for the SYSTEM-instruction execute sequencer
package csr_exec_pkg;

    // in_op encodings; 6 and 7 are illegal
    localparam logic [2:0] OP_CSRRW  = 3'd0;
    localparam logic [2:0] OP_CSRRS  = 3'd1;
    localparam logic [2:0] OP_CSRRC  = 3'd2;
    localparam logic [2:0] OP_ECALL  = 3'd3;
    localparam logic [2:0] OP_MRET   = 3'd4;
    localparam logic [2:0] OP_EBREAK = 3'd5;

    // CSR unit control codes
    localparam logic [2:0] CTRL_NONE   = 3'b000;
    localparam logic [2:0] CTRL_MRET   = 3'b001;
    localparam logic [2:0] CTRL_ECALL  = 3'b010;
    localparam logic [2:0] CTRL_EBREAK = 3'b011;
    localparam logic [2:0] CTRL_CSRW   = 3'b100;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [31:0] MCAUSE_ECALL_M = 32'h0000_000b;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/csr_exec_seq_alu.sv
// rtl/csr_exec_seq_alu.sv - combinational read-modify-write value for CSR instructions
module csr_alu
    import csr_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        case (op)
            OP_CSRRW: new_val = src;
            OP_CSRRS: new_val = old_val | src;
            OP_CSRRC: new_val = old_val & ~src;
            default:  new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_exec_seq.sv
// rtl/csr_exec_seq.sv - IDLE/READ/WRITE/RESP sequencer in front of the CSR unit
module csr_exec_seq
    import csr_exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_csr,
    input  logic [XLEN-1:0]   in_src,
    input  logic              in_src_zero,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_pc,
    output logic              csr_valid,
    output logic              csr_wen,
    output logic [2:0]        csr_ctrl,
    output logic [ADDR_W-1:0] csr_raddr,
    output logic [ADDR_W-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic [XLEN-1:0]   csr_pc,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic [XLEN-1:0]   csr_upc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_rd,
    output logic              out_rd_wen,
    output logic [XLEN-1:0]   out_rd_data,
    output logic              out_redirect,
    output logic [XLEN-1:0]   out_redirect_pc,
    output logic              out_ebreak
);

    state_e state, state_next;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] csr_q;
    logic [XLEN-1:0]   src_q;
    logic              src_zero_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   old_q;
    logic [XLEN-1:0]   target_q;
    logic [XLEN-1:0]   new_q;
    logic [XLEN-1:0]   alu_new;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .op      (op_q),
        .old_val (csr_rdata),
        .src     (src_q),
        .new_val (alu_new)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            csr_q      <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            rd_q       <= '0;
            pc_q       <= '0;
            old_q      <= '0;
            target_q   <= '0;
            new_q      <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q       <= in_op;
                        csr_q      <= in_csr;
                        src_q      <= in_src;
                        src_zero_q <= in_src_zero;
                        rd_q       <= in_rd;
                        pc_q       <= in_pc;
                    end
                end
                ST_READ: begin
                    old_q    <= csr_rdata;
                    target_q <= csr_upc;
                    new_q    <= alu_new;
                end
                default: ;
            endcase
        end
    end

    // csr_raddr follows the latched address so it holds its last value in IDLE/RESP
    assign csr_raddr = csr_q;

    always_comb begin
        state_next      = state;
        in_ready        = 1'b0;
        csr_valid       = 1'b0;
        csr_wen         = 1'b0;
        csr_ctrl        = CTRL_NONE;
        csr_waddr       = '0;
        csr_wdata       = '0;
        csr_pc          = '0;
        out_valid       = 1'b0;
        out_rd          = '0;
        out_rd_wen      = 1'b0;
        out_rd_data     = '0;
        out_redirect    = 1'b0;
        out_redirect_pc = '0;
        out_ebreak      = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_READ;
            end
            ST_READ: begin
                // ctrl during READ selects which trap/return target csr_upc presents
                if (op_q == OP_ECALL) begin
                    csr_ctrl = CTRL_ECALL;
                    csr_pc   = pc_q;
                end else if (op_q == OP_MRET) begin
                    csr_ctrl = CTRL_MRET;
                end
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                csr_valid = 1'b1;
                if (is_csr_op(op_q)) begin
                    csr_ctrl  = CTRL_CSRW;
                    csr_waddr = csr_q;
                    csr_wdata = new_q;
                    // set/clear with a zero source must not touch the CSR
                    csr_wen   = (op_q == OP_CSRRW) || !src_zero_q;
                end else if (op_q == OP_ECALL) begin
                    csr_ctrl = CTRL_ECALL;
                    csr_wen  = 1'b1;
                    csr_pc   = pc_q;
                end else if (op_q == OP_MRET) begin
                    csr_ctrl = CTRL_MRET;
                end else if (op_q == OP_EBREAK) begin
                    csr_ctrl = CTRL_EBREAK;
                end
                state_next = ST_RESP;
            end
            ST_RESP: begin
                out_valid       = 1'b1;
                out_rd          = rd_q;
                out_rd_wen      = is_csr_op(op_q) && (rd_q != 5'd0);
                out_rd_data     = old_q;
                out_redirect    = (op_q == OP_ECALL) || (op_q == OP_MRET);
                out_redirect_pc = target_q;
                out_ebreak      = (op_q == OP_EBREAK);
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_exec_seq.sv
// tb/tb_csr_exec_seq.sv - directed self-checking bench for csr_exec_seq with a small CSR unit model
module tb_csr_exec_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [11:0] in_csr;
    logic [31:0] in_src;
    logic        in_src_zero;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic        csr_valid;
    logic        csr_wen;
    logic [2:0]  csr_ctrl;
    logic [11:0] csr_raddr;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_pc;
    logic [31:0] csr_rdata;
    logic [31:0] csr_upc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [31:0] out_rd_data;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;
    logic        out_ebreak;

    int n_checks = 0;
    int n_pass   = 0;
    int wen_seen;

    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

    always #5 clock = ~clock;

    csr_exec_seq #(.XLEN(32), .ADDR_W(12)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_csr          (in_csr),
        .in_src          (in_src),
        .in_src_zero     (in_src_zero),
        .in_rd           (in_rd),
        .in_pc           (in_pc),
        .csr_valid       (csr_valid),
        .csr_wen         (csr_wen),
        .csr_ctrl        (csr_ctrl),
        .csr_raddr       (csr_raddr),
        .csr_waddr       (csr_waddr),
        .csr_wdata       (csr_wdata),
        .csr_pc          (csr_pc),
        .csr_rdata       (csr_rdata),
        .csr_upc         (csr_upc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_rd          (out_rd),
        .out_rd_wen      (out_rd_wen),
        .out_rd_data     (out_rd_data),
        .out_redirect    (out_redirect),
        .out_redirect_pc (out_redirect_pc),
        .out_ebreak      (out_ebreak)
    );

    // CSR unit model: combinational read, trap target mux, write on csr_valid && csr_wen
    always_comb begin
        case (csr_raddr)
            12'h300: csr_rdata = m_mstatus;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = 32'h0;
        endcase
        case (csr_ctrl)
            3'b010:  csr_upc = m_mtvec;
            3'b001:  csr_upc = m_mepc;
            default: csr_upc = 32'h0;
        endcase
    end

    always @(posedge clock) begin
        if (csr_valid && csr_wen) begin
            if (csr_ctrl == 3'b100) begin
                case (csr_waddr)
                    12'h300: m_mstatus <= csr_wdata;
                    12'h305: m_mtvec   <= csr_wdata;
                    12'h341: m_mepc    <= csr_wdata;
                    12'h342: m_mcause  <= csr_wdata;
                    default: ;
                endcase
            end else if (csr_ctrl == 3'b010) begin
                m_mepc   <= csr_pc;
                m_mcause <= 32'h0000_000b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Presents one instruction in IDLE and returns at the READ-cycle negedge
    task automatic start(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                         input logic zero, input logic [4:0] rd, input logic [31:0] pc);
        check("accept_in_ready", {31'h0, in_ready}, 32'h1);
        in_valid    = 1'b1;
        in_op       = op;
        in_csr      = csr;
        in_src      = src;
        in_src_zero = zero;
        in_rd       = rd;
        in_pc       = pc;
        tick();
        in_valid    = 1'b0;
        in_op       = 3'd0;
        in_src      = 32'h0;
    endtask

    task automatic finish_resp();
        tick();
        check("drop_out_valid", {31'h0, out_valid}, 32'h0);
        check("idle_in_ready", {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_op = 3'd0; in_csr = 12'h0; in_src = 32'h0;
        in_src_zero = 1'b0; in_rd = 5'd0; in_pc = 32'h0; out_ready = 1'b1;
        m_mstatus = 32'h0; m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
        repeat (2) tick();
        check("rst_csr_valid", {31'h0, csr_valid}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_raddr", {20'h0, csr_raddr}, 32'h0);
        check("rst_rd_data", out_rd_data, 32'h0);
        check("rst_ctrl", {29'h0, csr_ctrl}, 32'h0);

        // CSRRW mtvec
        start(3'd0, 12'h305, 32'h8000_0100, 1'b0, 5'd5, 32'h0);
        check("rw_read_raddr", {20'h0, csr_raddr}, 32'h305);
        check("rw_read_valid", {31'h0, csr_valid}, 32'h0);
        check("rw_read_inrdy", {31'h0, in_ready}, 32'h0);
        check("rw_read_outv", {31'h0, out_valid}, 32'h0);
        tick();
        check("rw_wr_valid", {31'h0, csr_valid}, 32'h1);
        check("rw_wr_wen", {31'h0, csr_wen}, 32'h1);
        check("rw_wr_ctrl", {29'h0, csr_ctrl}, 32'h4);
        check("rw_wr_waddr", {20'h0, csr_waddr}, 32'h305);
        check("rw_wr_wdata", csr_wdata, 32'h8000_0100);
        check("rw_wr_outv", {31'h0, out_valid}, 32'h0);
        tick();
        check("rw_resp_valid", {31'h0, out_valid}, 32'h1);
        check("rw_resp_rdwen", {31'h0, out_rd_wen}, 32'h1);
        check("rw_resp_rd", {27'h0, out_rd}, 32'h5);
        check("rw_resp_data", out_rd_data, 32'h0);
        check("rw_resp_redir", {31'h0, out_redirect}, 32'h0);
        check("rw_resp_csrv", {31'h0, csr_valid}, 32'h0);
        check("rw_mtvec", m_mtvec, 32'h8000_0100);
        finish_resp();

        // CSRRS mcause, then again with zero source
        m_mcause = 32'h0000_000b;
        start(3'd1, 12'h342, 32'h10, 1'b0, 5'd7, 32'h0);
        tick();
        check("rs_wdata", csr_wdata, 32'h0000_001b);
        check("rs_wen", {31'h0, csr_wen}, 32'h1);
        tick();
        check("rs_data", out_rd_data, 32'h0000_000b);
        check("rs_mcause", m_mcause, 32'h0000_001b);
        finish_resp();
        m_mcause = 32'h0000_000b;
        start(3'd1, 12'h342, 32'h0, 1'b1, 5'd7, 32'h0);
        tick();
        check("rs0_wen", {31'h0, csr_wen}, 32'h0);
        check("rs0_valid", {31'h0, csr_valid}, 32'h1);
        tick();
        check("rs0_data", out_rd_data, 32'h0000_000b);
        check("rs0_rdwen", {31'h0, out_rd_wen}, 32'h1);
        check("rs0_mcause", m_mcause, 32'h0000_000b);
        finish_resp();

        // CSRRC mstatus
        m_mstatus = 32'h0000_00ff;
        start(3'd2, 12'h300, 32'h0000_000f, 1'b0, 5'd1, 32'h0);
        tick();
        check("rc_wdata", csr_wdata, 32'h0000_00f0);
        tick();
        check("rc_data", out_rd_data, 32'h0000_00ff);
        check("rc_mstatus", m_mstatus, 32'h0000_00f0);
        finish_resp();

        // ECALL with mtvec = 0x8000_0100 from the CSRRW above
        start(3'd3, 12'h0, 32'h0, 1'b1, 5'd0, 32'h8000_0040);
        check("ec_read_ctrl", {29'h0, csr_ctrl}, 32'h2);
        check("ec_read_wen", {31'h0, csr_wen}, 32'h0);
        tick();
        check("ec_wr_wen", {31'h0, csr_wen}, 32'h1);
        check("ec_wr_ctrl", {29'h0, csr_ctrl}, 32'h2);
        check("ec_wr_pc", csr_pc, 32'h8000_0040);
        tick();
        check("ec_redir", {31'h0, out_redirect}, 32'h1);
        check("ec_redir_pc", out_redirect_pc, 32'h8000_0100);
        check("ec_rdwen", {31'h0, out_rd_wen}, 32'h0);
        check("ec_mepc", m_mepc, 32'h8000_0040);
        check("ec_mcause", m_mcause, 32'h0000_000b);
        finish_resp();

        // MRET
        m_mepc = 32'h8000_0044;
        start(3'd4, 12'h0, 32'h0, 1'b1, 5'd3, 32'h0);
        wen_seen = int'(csr_wen);
        check("mr_read_ctrl", {29'h0, csr_ctrl}, 32'h1);
        tick();
        wen_seen = wen_seen + int'(csr_wen);
        tick();
        check("mr_wen_never", wen_seen, 32'h0);
        check("mr_redir", {31'h0, out_redirect}, 32'h1);
        check("mr_redir_pc", out_redirect_pc, 32'h8000_0044);
        check("mr_rdwen", {31'h0, out_rd_wen}, 32'h0);
        finish_resp();

        // EBREAK
        start(3'd5, 12'h0, 32'h0, 1'b1, 5'd0, 32'h0);
        tick();
        check("eb_wen", {31'h0, csr_wen}, 32'h0);
        tick();
        check("eb_flag", {31'h0, out_ebreak}, 32'h1);
        check("eb_redir", {31'h0, out_redirect}, 32'h0);
        finish_resp();

        // Illegal op: no flags, no write
        start(3'd6, 12'h305, 32'hffff_ffff, 1'b0, 5'd9, 32'h0);
        tick();
        check("il_wen", {31'h0, csr_wen}, 32'h0);
        tick();
        check("il_flags", {29'h0, out_rd_wen, out_redirect, out_ebreak}, 32'h0);
        check("il_mtvec", m_mtvec, 32'h8000_0100);
        finish_resp();

        // CSRRW with rd = x0
        start(3'd0, 12'h341, 32'h1234, 1'b0, 5'd0, 32'h0);
        repeat (2) tick();
        check("x0_rdwen", {31'h0, out_rd_wen}, 32'h0);
        finish_resp();

        // Writeback stall in RESP
        m_mstatus = 32'h0000_00a5;
        out_ready = 1'b0;
        start(3'd0, 12'h300, 32'h0000_0055, 1'b0, 5'd4, 32'h0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            check("st_valid", {31'h0, out_valid}, 32'h1);
            check("st_data", out_rd_data, 32'h0000_00a5);
            check("st_in_ready", {31'h0, in_ready}, 32'h0);
            check("st_csr_valid", {31'h0, csr_valid}, 32'h0);
            tick();
        end
        check("st_mstatus", m_mstatus, 32'h0000_0055);
        out_ready = 1'b1;
        finish_resp();

        // Reset during WRITE drops the pending write
        start(3'd0, 12'h305, 32'h1234_5678, 1'b0, 5'd2, 32'h0);
        tick();
        check("rw2_wr_valid", {31'h0, csr_valid}, 32'h1);
        reset = 1'b1;
        #1;
        check("ar_csr_valid", {31'h0, csr_valid}, 32'h0);
        check("ar_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        check("ar_mtvec", m_mtvec, 32'h8000_0100);
        check("ar_out_valid", {31'h0, out_valid}, 32'h0);
        reset = 1'b0;
        tick();
        check("ar_idle_ready", {31'h0, in_ready}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
